inject_arbiter: RTL and testbench
=================================

# inject_arbiter

Packet-granular arbiter that merges the management-injector and application-injector flit streams onto the single shared external injection port of the many-core. It sits between the two TaskParser-style sources and the many-core's injection input. Once a source is granted, it holds the port for exactly one whole packet, so packets are never interleaved. Both sides use the codebase's credit-based flit handshake.

## Interface
- FLIT_SIZE, 32, flit width in bits
- MA_PRIORITY, 1, 1 = management source wins every contended decision; 0 = round-robin
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ma_rx_i  in  1  management source has a valid flit
- ma_credit_o  out  1  management flit accepted this cycle
- ma_data_i  in  FLIT_SIZE  management flit
- app_rx_i  in  1  application source has a valid flit
- app_credit_o  out  1  application flit accepted this cycle
- app_data_i  in  FLIT_SIZE  application flit
- tx_o  out  1  valid flit toward the many-core
- credit_i  in  1  many-core accepts a flit this cycle
- data_o  out  FLIT_SIZE  flit toward the many-core
- grant_o  out  1  current owner: 0 = management, 1 = application; valid while busy_o
- busy_o  out  1  a packet is being forwarded

## Operation
- Transfer rule: a flit moves when the selected source's rx and credit_i are both high in the same cycle.
- Packet format: flit 0 is the header; flit 1 is the payload count N (full flit, unsigned); N payload flits follow. Total = N + 2.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE:
  - If any rx is high, register the grant and go to HEADER.
  - Contended with MA_PRIORITY=1: grant management.
  - Contended with MA_PRIORITY=0: grant the source not served last. last_grant resets to 1, so management wins the first contention.
- HEADER: on transfer, go to SIZE.
- SIZE:
  - On transfer, load remaining ← data.
  - If data == 0, go to IDLE and update last_grant.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Each transfer decrements remaining.
  - A transfer with remaining == 1 goes to IDLE and updates last_grant.
- Datapath in HEADER/SIZE/PAYLOAD is combinational, with no buffering:
  - data_o = granted source data.
  - tx_o = granted source rx.
  - granted credit_o = credit_i.
  - non-granted credit_o = 0.
- In IDLE: tx_o = 0, both credit_o = 0, data_o = 0.
- The granted source dropping rx mid-packet stalls the port. Ownership never changes before the last flit.
- credit_i low: all state holds and nothing is consumed.

## Timing
- Reset values: tx_o 0, ma_credit_o 0, app_credit_o 0, data_o 0, grant_o 0, busy_o 0, state IDLE, remaining 0, last_grant 1.
- Assertion of rst_ni at any point aborts the packet in flight. The FSM returns to IDLE immediately and all outputs go to their reset values.
- Arbitration costs one bubble cycle: rx sampled in IDLE at cycle t means the earliest header transfer is at t+1.
- Minimum packet occupancy is N+2 cycles plus 1 IDLE cycle. Back-to-back packets from the same source therefore have exactly one bubble between them.
- busy_o = state != IDLE, registered. grant_o changes only on the IDLE→HEADER transition.
- remaining is FLIT_SIZE wide and needs no wrap handling: N = 2^FLIT_SIZE−1 counts down correctly.
- Combinational paths: rx → tx_o, credit_i → credit_o, data → data_o. No path from credit_i feeds FSM next-state except through the transfer condition.

## Structure
- PhiversPkg holds:
  - `inj_arb_state_t`, the enum {IDLE, HEADER, SIZE, PAYLOAD}.
  - `INJ_GRANT_MA` = 1'b0 and `INJ_GRANT_APP` = 1'b1.
- One sub-module is natural: `inj_pkt_counter`. It owns the HEADER/SIZE/PAYLOAD framing and `remaining`, and signals `last_flit`. The arbiter keeps the grant and last_grant logic.
- The testbench instantiates the block between the two injector instances and the many-core injection port. mapper_address and eoa bypass it.

## Test plan
- Single app packet: header 0x0000_0102, N=3, payloads 0xA..0xC, credit_i always 1 → exactly 5 flits on data_o in order on cycles t+1..t+5, busy_o falls after the 5th, grant_o=1.
- N=0: app sends header + size 0 → 2 flits transferred, FSM back to IDLE, app_credit_o low afterwards.
- Contention with MA_PRIORITY=1: both sources hold 3-flit packets (N=1) continuously → every packet is management; app_credit_o never asserts.
- Round-robin with MA_PRIORITY=0: both request continuously with N=1 → grant order MA, APP, MA, APP, with one bubble between packets and no interleaved flits.
- Backpressure: credit_i toggles 1,0,0,1 during PAYLOAD of N=4 → remaining decrements only on credit cycles, no duplicated or lost flits, and the other source stays blocked.
- Reset mid-packet: assert rst_ni low after flit 2 of an N=5 packet → all outputs are 0 in the same cycle; after release, a fresh app packet is forwarded from its header.

Source files
------------

// File: rtl/inject_arbiter_pkg.sv
// Shared types and helpers for the injection-port arbiter.
package inject_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } inj_arb_state_t;

    localparam logic INJ_GRANT_MA  = 1'b0;
    localparam logic INJ_GRANT_APP = 1'b1;

    // Arbitration decision taken in IDLE; only meaningful when at least one rx is high.
    function automatic logic pick_grant(
        input logic ma_rx,
        input logic app_rx,
        input logic ma_priority,
        input logic last_grant
    );
        logic g;
        if (ma_rx && app_rx) begin
            g = ma_priority ? INJ_GRANT_MA : ~last_grant;
        end else if (app_rx) begin
            g = INJ_GRANT_APP;
        end else begin
            g = INJ_GRANT_MA;
        end
        return g;
    endfunction

endpackage

// File: rtl/inj_pkt_counter.sv
// Packet framing FSM: tracks header, size and payload flits of the packet in flight.
module inj_pkt_counter
    import inject_arbiter_pkg::*;
#(
    parameter int FLIT_SIZE = 32
)
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start,
    input  logic                 xfer,
    input  logic [FLIT_SIZE-1:0] size_flit,
    output inj_arb_state_t       state,
    output logic                 last_flit
);

    inj_arb_state_t       state_next;
    logic [FLIT_SIZE-1:0] remaining;
    logic [FLIT_SIZE-1:0] remaining_next;

    // State and payload counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Next-state: advance only on a transfer; flag the flit that closes the packet.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        last_flit      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_next = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    remaining_next = size_flit;
                    if (size_flit == '0) begin
                        last_flit  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    remaining_next = remaining - FLIT_SIZE'(1);
                    if (remaining == FLIT_SIZE'(1)) begin
                        last_flit  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/inject_arbiter.sv
// Packet-granular arbiter merging management and application flit streams onto one injection port.
module inject_arbiter
    import inject_arbiter_pkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter bit MA_PRIORITY = 1'b1
)
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ma_rx_i,
    output logic                 ma_credit_o,
    input  logic [FLIT_SIZE-1:0] ma_data_i,
    input  logic                 app_rx_i,
    output logic                 app_credit_o,
    input  logic [FLIT_SIZE-1:0] app_data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 grant_o,
    output logic                 busy_o
);

    inj_arb_state_t       state;
    logic                 busy;
    logic                 start;
    logic                 last_flit;
    logic                 grant;
    logic                 last_grant;
    logic                 sel_rx;
    logic                 xfer;
    logic [FLIT_SIZE-1:0] sel_data;

    assign busy  = (state != IDLE);
    assign start = (state == IDLE) && (ma_rx_i || app_rx_i);

    // Combinational pass-through from the granted source; everything idles to zero.
    always_comb begin
        sel_rx       = 1'b0;
        sel_data     = '0;
        xfer         = 1'b0;
        tx_o         = 1'b0;
        data_o       = '0;
        ma_credit_o  = 1'b0;
        app_credit_o = 1'b0;
        if (busy) begin
            sel_rx       = (grant == INJ_GRANT_APP) ? app_rx_i   : ma_rx_i;
            sel_data     = (grant == INJ_GRANT_APP) ? app_data_i : ma_data_i;
            xfer         = sel_rx && credit_i;
            tx_o         = sel_rx;
            data_o       = sel_data;
            ma_credit_o  = (grant == INJ_GRANT_MA)  && credit_i;
            app_credit_o = (grant == INJ_GRANT_APP) && credit_i;
        end
    end

    // Ownership: latch the winner on IDLE->HEADER, remember it once the packet closes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant      <= INJ_GRANT_MA;
            last_grant <= INJ_GRANT_APP;
        end else begin
            if (start) begin
                grant <= pick_grant(ma_rx_i, app_rx_i, MA_PRIORITY, last_grant);
            end
            if (last_flit) begin
                last_grant <= grant;
            end
        end
    end

    inj_pkt_counter #(
        .FLIT_SIZE(FLIT_SIZE)
    ) u_pkt_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start     (start),
        .xfer      (xfer),
        .size_flit (sel_data),
        .state     (state),
        .last_flit (last_flit)
    );

    assign grant_o = grant;
    assign busy_o  = busy;

endmodule

// File: tb/tb_inject_arbiter.sv
// Bench for inject_arbiter: two instances (priority and round-robin) against a packet-level model.
module tb_inject_arbiter;

    localparam int          W  = 32;
    localparam int unsigned QD = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         ma_rx [2];
    logic         app_rx[2];
    logic         credit[2];
    logic         tx    [2];
    logic         ma_cr [2];
    logic         app_cr[2];
    logic         grant [2];
    logic         busy  [2];
    logic [W-1:0] ma_data [2];
    logic [W-1:0] app_data[2];
    logic [W-1:0] data    [2];

    always #5 clk = ~clk;

    inject_arbiter #(.FLIT_SIZE(W), .MA_PRIORITY(1'b1)) u_prio (
        .clk_i(clk), .rst_ni(rst_n),
        .ma_rx_i(ma_rx[0]), .ma_credit_o(ma_cr[0]), .ma_data_i(ma_data[0]),
        .app_rx_i(app_rx[0]), .app_credit_o(app_cr[0]), .app_data_i(app_data[0]),
        .tx_o(tx[0]), .credit_i(credit[0]), .data_o(data[0]),
        .grant_o(grant[0]), .busy_o(busy[0])
    );

    inject_arbiter #(.FLIT_SIZE(W), .MA_PRIORITY(1'b0)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .ma_rx_i(ma_rx[1]), .ma_credit_o(ma_cr[1]), .ma_data_i(ma_data[1]),
        .app_rx_i(app_rx[1]), .app_credit_o(app_cr[1]), .app_data_i(app_data[1]),
        .tx_o(tx[1]), .credit_i(credit[1]), .data_o(data[1]),
        .grant_o(grant[1]), .busy_o(busy[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source flit queues: [dut][source 0=ma,1=app][slot]; qt = flits left in packet including this one.
    logic [W-1:0] qd[2][2][QD];
    int unsigned  qt[2][2][QD];
    int unsigned  wr[2][2];
    int unsigned  rd[2][2];
    bit           en[2][2];
    int unsigned  rx_pct = 100;
    int unsigned  cr_pct = 100;
    bit           cr_q[$];

    // Packet-level model state per DUT.
    bit          m_busy[2];
    bit          m_own [2];
    bit          m_last[2];
    int unsigned m_left[2];

    // Observation logs.
    logic [W-1:0] lg_data [2][256];
    int           lg_cyc  [2][256];
    bit           lg_grant[2][256];
    int           lg_n[2];
    bit           hd_grant[2][64];
    int           hd_cyc  [2][64];
    int           hd_n[2];
    bit           prev_busy[2];
    int           ma_cr_n[2];
    int           app_cr_n[2];

    logic [W-1:0] exp1[5] = '{32'h0000_0102, 32'h3, 32'hA, 32'hB, 32'hC};
    logic [W-1:0] exp5[6] = '{32'hB0B0_0001, 32'h4, 32'hB100, 32'hB101, 32'hB102, 32'hB103};
    int           off5[6] = '{1, 2, 3, 6, 7, 8};

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int s, input logic [W-1:0] v, input int unsigned t);
        qd[d][s][wr[d][s] % QD] = v;
        qt[d][s][wr[d][s] % QD] = t;
        wr[d][s]++;
    endtask

    task automatic enq(input int d, input int s, input logic [W-1:0] hdr,
                       input int unsigned n, input logic [W-1:0] pbase);
        push(d, s, hdr, n + 2);
        push(d, s, W'(n), n + 1);
        for (int unsigned i = 0; i < n; i++) push(d, s, pbase + W'(i), n - i);
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_own[d]  = 1'b0;
            m_last[d] = 1'b1;
            m_left[d] = 0;
            for (int s = 0; s < 2; s++) rd[d][s] = wr[d][s];
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            lg_n[d] = 0; hd_n[d] = 0; ma_cr_n[d] = 0; app_cr_n[d] = 0;
        end
    endtask

    // Packet-level rules: pick an owner when idle, then consume whole packets from that owner only.
    task automatic model_step(input int d);
        bit rm, ra, rs;
        int s;
        rm = ma_rx[d];
        ra = app_rx[d];
        if (!m_busy[d]) begin
            if (rm || ra) begin
                if (rm && ra) m_own[d] = (d == 0) ? 1'b0 : ~m_last[d];
                else          m_own[d] = ra;
                s = m_own[d] ? 1 : 0;
                m_busy[d] = 1'b1;
                m_left[d] = qt[d][s][rd[d][s] % QD];
            end
        end else begin
            s  = m_own[d] ? 1 : 0;
            rs = m_own[d] ? ra : rm;
            if (rs && credit[d]) begin
                rd[d][s]++;
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_busy[d] = 1'b0;
                    m_last[d] = m_own[d];
                end
            end
        end
    endtask

    task automatic drive();
        bit c;
        c = (cr_q.size() > 0) ? cr_q.pop_front() : ($urandom_range(99) < cr_pct);
        for (int d = 0; d < 2; d++) begin
            credit[d] = c;
            if (wr[d][0] != rd[d][0]) begin
                ma_data[d] = qd[d][0][rd[d][0] % QD];
                ma_rx[d]   = en[d][0] && ($urandom_range(99) < rx_pct);
            end else begin
                ma_data[d] = $urandom;
                ma_rx[d]   = 1'b0;
            end
            if (wr[d][1] != rd[d][1]) begin
                app_data[d] = qd[d][1][rd[d][1] % QD];
                app_rx[d]   = en[d][1] && ($urandom_range(99) < rx_pct);
            end else begin
                app_data[d] = $urandom;
                app_rx[d]   = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic         ex_tx;
        logic [W-1:0] ex_data;
        for (int d = 0; d < 2; d++) begin
            ex_tx   = m_busy[d] && (m_own[d] ? app_rx[d] : ma_rx[d]);
            ex_data = !m_busy[d] ? '0 : (m_own[d] ? app_data[d] : ma_data[d]);
            chk1($sformatf("tx[%0d]", d), tx[d], ex_tx);
            chkw($sformatf("data[%0d]", d), data[d], ex_data);
            chk1($sformatf("ma_credit[%0d]", d), ma_cr[d], m_busy[d] && !m_own[d] && credit[d]);
            chk1($sformatf("app_credit[%0d]", d), app_cr[d], m_busy[d] && m_own[d] && credit[d]);
            chk1($sformatf("busy[%0d]", d), busy[d], m_busy[d]);
            if (m_busy[d]) chk1($sformatf("grant[%0d]", d), grant[d], m_own[d]);
            if (tx[d] && credit[d] && lg_n[d] < 256) begin
                lg_data[d][lg_n[d]]  = data[d];
                lg_cyc[d][lg_n[d]]   = cyc;
                lg_grant[d][lg_n[d]] = grant[d];
                lg_n[d]++;
            end
            if (busy[d] && !prev_busy[d] && hd_n[d] < 64) begin
                hd_grant[d][hd_n[d]] = grant[d];
                hd_cyc[d][hd_n[d]]   = cyc;
                hd_n[d]++;
            end
            prev_busy[d] = busy[d];
            if (ma_cr[d])  ma_cr_n[d]++;
            if (app_cr[d]) app_cr_n[d]++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1 drive();
        #1 check_outputs();
    endtask

    int start;

    initial begin
        reset_model();
        clear_logs();
        drive();
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            chk1("rst_tx", tx[d], 1'b0);
            chk1("rst_busy", busy[d], 1'b0);
            chk1("rst_grant", grant[d], 1'b0);
            chkw("rst_data", data[d], '0);
        end
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single application packet, N=3, full credit.
        clear_logs();
        rx_pct = 100; cr_pct = 100;
        for (int d = 0; d < 2; d++) begin
            enq(d, 1, 32'h0000_0102, 3, 32'hA);
            en[d][1] = 1'b1;
        end
        start = cyc + 1;
        repeat (8) cycle();
        for (int d = 0; d < 2; d++) begin
            chkw("t1_count", W'(lg_n[d]), 32'd5);
            for (int i = 0; i < 5; i++) begin
                chkw("t1_flit", lg_data[d][i], exp1[i]);
                chkw("t1_cyc", W'(lg_cyc[d][i]), W'(start + 1 + i));
                chk1("t1_grant", lg_grant[d][i], 1'b1);
            end
        end

        // Zero-length payload.
        clear_logs();
        for (int d = 0; d < 2; d++) enq(d, 1, 32'h0000_0200, 0, 32'h0);
        repeat (6) cycle();
        for (int d = 0; d < 2; d++) begin
            chkw("t2_count", W'(lg_n[d]), 32'd2);
            chkw("t2_size", lg_data[d][1], 32'h0);
            chk1("t2_app_cr_after", app_cr[d], 1'b0);
            chk1("t2_busy_after", busy[d], 1'b0);
        end

        // Contention: priority instance vs round-robin instance, N=1 packets.
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                enq(d, 0, 32'h4D00_0000 + W'(k), 1, 32'h4D10_0000 + W'(k));
                enq(d, 1, 32'hA500_0000 + W'(k), 1, 32'hA510_0000 + W'(k));
            end
            en[d][0] = 1'b1;
            en[d][1] = 1'b1;
        end
        repeat (16) cycle();
        chkw("prio_app_credits", W'(app_cr_n[0]), 32'd0);
        chkw("prio_pkts", W'(hd_n[0]), 32'd4);
        chkw("rr_pkts", W'(hd_n[1]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk1("prio_order", hd_grant[0][i], 1'b0);
            chk1("rr_order", hd_grant[1][i], (i % 2) == 1);
        end
        for (int i = 0; i < 3; i++) chkw("rr_gap", W'(hd_cyc[1][i + 1] - hd_cyc[1][i]), 32'd4);
        repeat (24) cycle();

        // Backpressure during payload; management waits behind the application packet.
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            en[d][0] = 1'b0;
            en[d][1] = 1'b1;
            enq(d, 1, 32'hB0B0_0001, 4, 32'hB100);
            enq(d, 0, 32'h4D4D_0001, 0, 32'h0);
        end
        cr_q = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        start = cyc + 1;
        cycle();
        for (int d = 0; d < 2; d++) en[d][0] = 1'b1;
        repeat (9) cycle();
        for (int d = 0; d < 2; d++) chkw("bp_ma_blocked", W'(ma_cr_n[d]), 32'd0);
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            chkw("bp_count", W'(lg_n[d]), 32'd8);
            for (int i = 0; i < 6; i++) begin
                chkw("bp_flit", lg_data[d][i], exp5[i]);
                chkw("bp_cyc", W'(lg_cyc[d][i]), W'(start + off5[i]));
            end
            chkw("bp_next_hdr", lg_data[d][6], 32'h4D4D_0001);
            chk1("bp_next_grant", lg_grant[d][6], 1'b0);
        end

        // Reset in the middle of an N=5 packet.
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            en[d][0] = 1'b0;
            en[d][1] = 1'b1;
            enq(d, 1, 32'h5E5E_0000, 5, 32'h5E10);
        end
        for (int k = 0; k < 20 && lg_n[0] < 2; k++) cycle();
        chk1("rst_wait", lg_n[0] >= 2, 1'b1);
        cycle();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1("abort_tx", tx[d], 1'b0);
            chk1("abort_ma_cr", ma_cr[d], 1'b0);
            chk1("abort_app_cr", app_cr[d], 1'b0);
            chkw("abort_data", data[d], '0);
            chk1("abort_busy", busy[d], 1'b0);
            chk1("abort_grant", grant[d], 1'b0);
        end
        reset_model();
        for (int d = 0; d < 2; d++) en[d][1] = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            en[d][1] = 1'b1;
            enq(d, 1, 32'hF00D_0001, 1, 32'hF00E);
        end
        repeat (6) cycle();
        for (int d = 0; d < 2; d++) begin
            chkw("post_rst_count", W'(lg_n[d]), 32'd3);
            chkw("post_rst_hdr", lg_data[d][0], 32'hF00D_0001);
            chkw("post_rst_pay", lg_data[d][2], 32'hF00E);
        end

        // Randomized traffic with both sources and varying backpressure.
        rx_pct = 70;
        for (int d = 0; d < 2; d++) begin
            en[d][0] = 1'b1;
            en[d][1] = 1'b1;
        end
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) cr_pct = (k % 1500 == 0) ? 100 : ((k % 1000 == 0) ? 40 : 70);
            for (int d = 0; d < 2; d++)
                for (int s = 0; s < 2; s++)
                    if (wr[d][s] - rd[d][s] < 12)
                        enq(d, s, $urandom, $urandom_range(0, 6), $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
